odd_sum_squarer: RTL
====================

Name: odd_sum_squarer

Overview:
- Iterative squarer: the inverse of the square-root finder.
- Given an unsigned root n, it computes n*n by accumulating the first n odd numbers (1+3+5+...), one addition per clock.
- Used to generate and check perfect squares for the square-root block.
- Controller and datapath live in one module with a start/busy/done handshake.

Parameters:
W, 4, root width in bits; result width is 2*W.

Ports:
clk  input  1  system clock, all state updates on rising edge
clr  input  1  asynchronous active-high reset
start  input  1  request to begin a computation; sampled only in IDLE
n  input  W  root operand; captured on the accepted start edge
busy  output  1  high while a computation is in progress (state CALC)
done  output  1  registered one-cycle pulse; result valid and updated this cycle
sq  output  2*W  result register n*n; holds value until next completion

Behaviour:
- Reset (clr=1, asynchronous, overrides everything):
  - state=IDLE; sq=0, done=0, busy=0.
  - Internal cnt=0, acc=0, odd=1.
- Internal registers:
  - cnt: W bits, remaining additions.
  - acc: 2*W bits, running sum.
  - odd: W+1 bits, next odd term.
  - Width check: odd never exceeds 2^(W+1)-1, and acc never exceeds (2^W-1)^2, so no overflow for any n.
- States: IDLE, CALC. busy = (state==CALC), decoded combinationally from the state register.
- IDLE:
  - done is cleared to 0 on every edge unless set by a completion (single-cycle pulse).
  - If start=1: cnt<=n, acc<=0, odd<=1, state<=CALC.
  - If start=0: no change except done<=0.
- CALC with cnt!=0: acc<=acc+odd, odd<=odd+2, cnt<=cnt-1, stay CALC.
- CALC with cnt==0: sq<=acc, done<=1, state<=IDLE.
- Latency:
  - Start accepted at edge E0; done is high during the cycle after edge E(n+1).
  - That is n+1 cycles from acceptance to done; n=0 gives done one cycle after start.
- Handshake rules:
  - start while busy=1 is ignored (no restart, no queueing).
  - start asserted in the cycle where done=1 is accepted, because the state is IDLE. This gives back-to-back operation with no idle gap.
  - start held high continuously restarts a new computation immediately after each done.
  - n is don't-care except on the accepting edge; changes during CALC do not affect the result.
- sq changes only on the completion edge; it is stable at all other times, including during CALC of the next operation.
- clr asserted mid-CALC aborts the operation: no done pulse, sq=0, and the next start begins cleanly.
- clr deasserting in the same cycle as start: start is sampled at the first rising edge with clr=0.

Test Plan:
- Reset, then start with n=0 -> done pulses one cycle after the start edge, sq=0, busy never high for more than one cycle.
- n=3 -> busy high 4 cycles, acc sequence 1,4,9, done with sq=9; sq holds 9 for 20 idle cycles; done low thereafter.
- n=15 (W=4) -> done exactly 16 cycles after acceptance, sq=225 (0xE1), no overflow.
- start held high with n=5 then n=7 presented at the done cycle -> sq=25, then the next done gives sq=49 with no gap cycle. Pulsing start with n=2 mid-CALC is ignored.
- clr pulsed mid-CALC of n=12 -> outputs immediately 0 (asynchronous, before the next edge), no done pulse; a subsequent start with n=4 gives sq=16.
- Exhaustive sweep of n=0..15 with a random inter-start gap of 0-3 cycles -> every sq equals n*n and the latency always equals n+1.

Source files
------------

// File: rtl/odd_sum_squarer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | odd_sum_squarer                                                      |
// | Iterative squarer: n*n as the sum of the first n odd numbers,        |
// | one addition per clock, with a start/busy/done handshake.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module odd_sum_squarer #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           start,
  input  logic [W-1:0]   n,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] sq
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [W-1:0]   r_cnt;
  logic [2*W-1:0] r_acc;
  logic [W:0]     r_odd;
  logic [2*W-1:0] r_sq;
  logic           r_done;

  logic w_load;
  logic w_step;
  logic w_finish;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        if (r_cnt != '0) begin
          w_step = 1'b1;
        end else begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The odd term is zero-extended to the accumulator width (needs W >= 2).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_odd  <= (W+1)'(1);
      r_sq   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_cnt <= n;
        r_acc <= '0;
        r_odd <= (W+1)'(1);
      end else if (w_step) begin
        r_acc <= r_acc + {{(W-1){1'b0}}, r_odd};
        r_odd <= r_odd + (W+1)'(2);
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        r_sq <= r_acc;
      end
    end
  end

  assign busy = (r_state == CALC);
  assign done = r_done;
  assign sq   = r_sq;

endmodule
`default_nettype wire
